// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control path: opcodes, bus sources, ALU ops, states.
package cpu_pkg;

  localparam logic [5:0] OPC_NOP   = 6'd0;
  localparam logic [5:0] OPC_LOAD  = 6'd1;
  localparam logic [5:0] OPC_STORE = 6'd2;
  localparam logic [5:0] OPC_ADD   = 6'd3;
  localparam logic [5:0] OPC_JMP   = 6'd4;
  localparam logic [5:0] OPC_JZ    = 6'd5;
  localparam logic [5:0] OPC_HALT  = 6'd63;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_IR   = 3'd2,
    BUS_MEM  = 3'd3,
    BUS_AC   = 3'd4
  } bus_sel_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1
  } alu_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StFAr,
    StFMem,
    StDecode,
    StXAr,
    StXRd,
    StXWr,
    StXJmp,
    StHalt
  } state_e;

  // Decoded instruction class; held across the execute states.
  typedef enum logic [2:0] {
    OpNop,
    OpLoad,
    OpStore,
    OpAdd,
    OpJmp,
    OpJz,
    OpHalt,
    OpIllegal
  } op_class_e;

endpackage

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer owning every datapath enable of the accumulator CPU.
// Outputs decode combinationally from state; strobes gated by mem_ready are Mealy.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             ac_zero,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             pc_inc_en,
  output logic             ar_write_en,
  output logic             ir_write_en,
  output logic             ac_write_en,
  output logic [1:0]       alu_op,
  output logic [2:0]       bus_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e     state_q, state_d;
  op_class_e  op_q, op_d, op_dec;
  logic [CNT_W-1:0] cnt_q;
  bus_sel_e   bus_d;
  alu_op_e    alu_d;

  always_comb begin
    op_dec = OpIllegal;
    if      (opcode == OPC_W'(OPC_NOP))   op_dec = OpNop;
    else if (opcode == OPC_W'(OPC_LOAD))  op_dec = OpLoad;
    else if (opcode == OPC_W'(OPC_STORE)) op_dec = OpStore;
    else if (opcode == OPC_W'(OPC_ADD))   op_dec = OpAdd;
    else if (opcode == OPC_W'(OPC_JMP))   op_dec = OpJmp;
    else if (opcode == OPC_W'(OPC_JZ))    op_dec = OpJz;
    else if (opcode == OPC_W'(OPC_HALT))  op_dec = OpHalt;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_write_en = 1'b0;
    pc_inc_en   = 1'b0;
    ar_write_en = 1'b0;
    ir_write_en = 1'b0;
    ac_write_en = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    bus_d       = BUS_NONE;
    alu_d       = ALU_PASS;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFAr;
      end
      StFAr: begin
        bus_d       = BUS_PC;
        ar_write_en = 1'b1;
        state_d     = StFMem;
      end
      StFMem: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          bus_d       = BUS_MEM;
          ir_write_en = 1'b1;
          pc_inc_en   = 1'b1;
          state_d     = StDecode;
        end
      end
      StDecode: begin
        op_d = op_dec;
        case (op_dec)
          OpLoad, OpAdd, OpStore: state_d = StXAr;
          OpJmp:                  state_d = StXJmp;
          OpJz:                   state_d = ac_zero ? StXJmp : StFAr;
          OpHalt:                 state_d = StHalt;
          OpIllegal: begin
            illegal_op = 1'b1;
            state_d    = StFAr;
          end
          default:                state_d = StFAr;
        endcase
      end
      StXAr: begin
        bus_d       = BUS_IR;
        ar_write_en = 1'b1;
        state_d     = (op_q == OpStore) ? StXWr : StXRd;
      end
      StXRd: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          bus_d       = BUS_MEM;
          ac_write_en = 1'b1;
          alu_d       = (op_q == OpAdd) ? ALU_ADD : ALU_PASS;
          state_d     = StFAr;
        end
      end
      StXWr: begin
        bus_d  = BUS_AC;
        mem_wr = 1'b1;
        if (mem_ready) state_d = StFAr;
      end
      StXJmp: begin
        bus_d       = BUS_IR;
        pc_write_en = 1'b1;
        state_d     = StFAr;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_sel     = bus_d;
  assign alu_op      = alu_d;
  assign instr_count = cnt_q;

  // Every pass through DECODE retires one instruction, HALT and illegal ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (state_q == StDecode) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit; one cycle per vector, checked mid-cycle.
module tb_cpu_control_unit;

  localparam logic [8:0] E_PCW = 9'h100;
  localparam logic [8:0] E_PCI = 9'h080;
  localparam logic [8:0] E_ARW = 9'h040;
  localparam logic [8:0] E_IRW = 9'h020;
  localparam logic [8:0] E_ACW = 9'h010;
  localparam logic [8:0] E_RD  = 9'h008;
  localparam logic [8:0] E_WR  = 9'h004;
  localparam logic [8:0] E_ILL = 9'h002;
  localparam logic [8:0] E_HLT = 9'h001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  opcode;
  logic        ac_zero;
  logic        mem_ready;
  logic        pc_write_en, pc_inc_en, ar_write_en, ir_write_en, ac_write_en;
  logic [1:0]  alu_op;
  logic [2:0]  bus_sel;
  logic        mem_rd, mem_wr, halted, illegal_op;
  logic [15:0] instr_count;
  logic [8:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_control_unit #(
    .OPC_W(6),
    .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .ac_zero    (ac_zero),
    .mem_ready  (mem_ready),
    .pc_write_en(pc_write_en),
    .pc_inc_en  (pc_inc_en),
    .ar_write_en(ar_write_en),
    .ir_write_en(ir_write_en),
    .ac_write_en(ac_write_en),
    .alu_op     (alu_op),
    .bus_sel    (bus_sel),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .halted     (halted),
    .illegal_op (illegal_op),
    .instr_count(instr_count)
  );

  assign ctl = {pc_write_en, pc_inc_en, ar_write_en, ir_write_en, ac_write_en,
                mem_rd, mem_wr, illegal_op, halted};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive mem_ready, check outputs at the falling edge, land 1ns past the next rise.
  task automatic cyc(input string tag, input logic mr, input logic [8:0] e_ctl,
                     input logic [2:0] e_bus, input logic [1:0] e_alu);
    mem_ready = mr;
    @(negedge clk);
    check_eq({tag, ".ctl"}, 32'(ctl), 32'(e_ctl));
    check_eq({tag, ".bus"}, 32'(bus_sel), 32'(e_bus));
    check_eq({tag, ".alu"}, 32'(alu_op), 32'(e_alu));
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch: F_AR, F_MEM with immediate mem_ready, DECODE.
  task automatic fetch(input string tag, input logic [5:0] op, input logic [8:0] e_dec);
    opcode = op;
    cyc({tag, ".far"}, 1'b0, E_ARW, 3'd1, 2'd0);
    cyc({tag, ".fmem"}, 1'b1, E_RD | E_IRW | E_PCI, 3'd3, 2'd0);
    cyc({tag, ".dec"}, 1'b0, e_dec, 3'd0, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 6'd0; ac_zero = 1'b0; mem_ready = 1'b0;
    #1;
    check_eq("rst.ctl", 32'(ctl), 32'd0);
    check_eq("rst.bus", 32'(bus_sel), 32'd0);
    check_eq("rst.cnt", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run   = 1'b1;

    // NOP x3; mem_ready in DECODE must be ignored
    cyc("idle", 1'b0, 9'd0, 3'd0, 2'd0);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opcode = 6'd0;
      cyc("nop.far", 1'b0, E_ARW, 3'd1, 2'd0);
      cyc("nop.fmem", 1'b1, E_RD | E_IRW | E_PCI, 3'd3, 2'd0);
      cyc("nop.dec", 1'b1, 9'd0, 3'd0, 2'd0);
    end
    check_eq("nop.cnt", 32'(instr_count), 32'd3);

    // LOAD, two wait cycles on each access; IR change after decode must not matter
    opcode = 6'd1;
    cyc("ld.far", 1'b0, E_ARW, 3'd1, 2'd0);
    cyc("ld.fw0", 1'b0, E_RD, 3'd0, 2'd0);
    cyc("ld.fw1", 1'b0, E_RD, 3'd0, 2'd0);
    cyc("ld.fmem", 1'b1, E_RD | E_IRW | E_PCI, 3'd3, 2'd0);
    cyc("ld.dec", 1'b0, 9'd0, 3'd0, 2'd0);
    opcode = 6'd2;
    cyc("ld.xar", 1'b0, E_ARW, 3'd2, 2'd0);
    cyc("ld.rw0", 1'b0, E_RD, 3'd0, 2'd0);
    cyc("ld.rw1", 1'b0, E_RD, 3'd0, 2'd0);
    cyc("ld.xrd", 1'b1, E_RD | E_ACW, 3'd3, 2'd0);
    check_eq("ld.cnt", 32'(instr_count), 32'd4);

    // ADD, zero wait
    fetch("add", 6'd3, 9'd0);
    cyc("add.xar", 1'b0, E_ARW, 3'd2, 2'd0);
    cyc("add.xrd", 1'b1, E_RD | E_ACW, 3'd3, 2'd1);

    // STORE with one wait cycle
    fetch("st", 6'd2, 9'd0);
    cyc("st.xar", 1'b0, E_ARW, 3'd2, 2'd0);
    cyc("st.ww0", 1'b0, E_WR, 3'd4, 2'd0);
    cyc("st.xwr", 1'b1, E_WR, 3'd4, 2'd0);

    // JZ not taken falls straight into the next fetch; taken goes through X_JMP
    ac_zero = 1'b0;
    fetch("jz0", 6'd5, 9'd0);
    ac_zero = 1'b1;
    fetch("jz1", 6'd5, 9'd0);
    ac_zero = 1'b0;
    cyc("jz1.jmp", 1'b0, E_PCW, 3'd2, 2'd0);

    fetch("jmp", 6'd4, 9'd0);
    cyc("jmp.jmp", 1'b0, E_PCW, 3'd2, 2'd0);

    fetch("ill", 6'h2A, E_ILL);
    check_eq("ill.cnt", 32'(instr_count), 32'd10);

    // HALT is sticky regardless of run and mem_ready
    fetch("halt", 6'd63, 9'd0);
    for (int i = 0; i < 100; i++) begin
      run = i[0];
      cyc("halt.hold", i[1], E_HLT, 3'd0, 2'd0);
    end
    check_eq("halt.cnt", 32'(instr_count), 32'd11);

    // Reset out of HALT, then reset again while X_RD is requesting memory
    rst_n = 1'b0; #1;
    check_eq("rst2.ctl", 32'(ctl), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run   = 1'b1;
    cyc("rst2.idle", 1'b0, 9'd0, 3'd0, 2'd0);
    run = 1'b0;
    fetch("rd", 6'd1, 9'd0);
    cyc("rd.xar", 1'b0, E_ARW, 3'd2, 2'd0);
    mem_ready = 1'b0;
    #2;
    check_eq("rd.memrd", 32'(mem_rd), 32'd1);
    check_eq("rd.cnt", 32'(instr_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rd.rst_memrd", 32'(mem_rd), 32'd0);
    check_eq("rd.rst_cnt", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("post.rdy", 1'b1, 9'd0, 3'd0, 2'd0);
    cyc("post.idle0", 1'b0, 9'd0, 3'd0, 2'd0);
    cyc("post.idle1", 1'b0, 9'd0, 3'd0, 2'd0);
    run = 1'b1;
    cyc("post.run", 1'b0, 9'd0, 3'd0, 2'd0);
    cyc("post.far", 1'b0, E_ARW, 3'd1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
